instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the R-type pipeline's IF/ID boundary. Owns the PC, reads the

---
 rtl/if_pkg.sv | 15 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 81 ++++++++
 tb/tb_instr_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic lives here.
// No flow control lives here.
package if_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // One buffered fetch: the instruction word and the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: synchronous FIFO of fetch_entry_t between the PC/IMEM read and decode.
// Latency: an entry pushed at edge N is visible on head after edge N.
// Backpressure: the caller never pushes when full without popping; flush wins over push/pop.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // Storage array carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, reads combinational IMEM and hands {instr, pc, pc+4} to decode.
// Latency: one cycle from IMEM read to id_*; 1 instr/cycle sustained while id_ready is high.
// Backpressure: fetch stalls when the queue is full and decode is not dequeuing; redirect flushes.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        align_err
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]      pc;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     new_entry;
    logic             deq;
    logic             fire;
    logic             not_empty;

    assign not_empty = (count != '0);
    assign id_valid  = not_empty && !redirect_valid;
    assign deq       = id_valid && id_ready;
    // A dequeue in the same cycle frees the slot, so a full queue still fetches.
    assign fire      = !redirect_valid && ((count < CNT_W'(QUEUE_DEPTH)) || deq);

    assign new_entry.instr = imem_instr;
    assign new_entry.pc    = pc;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fire),
        .push_entry (new_entry),
        .pop        (deq),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    // PC register: redirect reloads a word-aligned target, otherwise advance on each fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (fire) begin
            pc <= pc + PC_STEP;
        end
    end

    // Misaligned-redirect flag: one-cycle pulse per offending redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else begin
            align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign imem_addr   = pc;
    assign id_instr    = not_empty ? head.instr : INSTR_NOP;
    assign id_pc       = not_empty ? head.pc : 32'h0;
    assign id_pc_plus4 = id_pc + PC_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; IMEM model returns 32'h1000_0000 + k at address 4k.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// All expected values are hand-computed constants.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        align_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .align_err      (align_err)
    );

    // Combinational instruction memory: word k sits at byte address 4k.
    assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = ready;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;

        // 1: reset state, then streaming with id_ready=1
        do_reset(1'b1);
        #1;
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'h4);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_align_err", {31'b0, align_err}, 32'd0);
        step();
        check("s1_valid_rise", {31'b0, id_valid}, 32'd1);
        check("s1_pc0", id_pc, 32'h0);
        check("s1_instr0", id_instr, 32'h1000_0000);
        step();
        check("s1_pc4", id_pc, 32'h4);
        check("s1_instr1", id_instr, 32'h1000_0001);
        step();
        check("s1_pc8", id_pc, 32'h8);
        check("s1_pc8_plus4", id_pc_plus4, 32'hC);
        step();
        check("s1_pc12", id_pc, 32'hC);
        check("s1_instr3", id_instr, 32'h1000_0003);

        // 2: decode stalled for 5 cycles, queue fills and holds
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step();
        check("s2_imem_addr_hold", imem_addr, 32'h8);
        check("s2_valid_full", {31'b0, id_valid}, 32'd1);
        check("s2_pc_hold", id_pc, 32'h0);
        check("s2_instr_hold", id_instr, 32'h1000_0000);
        id_ready = 1'b1;
        step();
        check("s2_drain_pc4", id_pc, 32'h4);
        check("s2_drain_valid", {31'b0, id_valid}, 32'd1);
        step();
        check("s2_drain_pc8", id_pc, 32'h8);

        // 3: redirect to 0x100 with two entries queued
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step();
        check("s3_full_addr", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("s3_valid_low_redirect", {31'b0, id_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        check("s3_imem_addr", imem_addr, 32'h100);
        check("s3_flushed", {31'b0, id_valid}, 32'd0);
        check("s3_no_align_err", {31'b0, align_err}, 32'd0);
        step();
        check("s3_id_pc", id_pc, 32'h100);
        check("s3_id_pc_plus4", id_pc_plus4, 32'h104);
        check("s3_id_instr", id_instr, 32'h1000_0040);

        // 4: misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        check("s4_imem_addr", imem_addr, 32'h200);
        check("s4_align_err_hi", {31'b0, align_err}, 32'd1);
        step();
        check("s4_align_err_lo", {31'b0, align_err}, 32'd0);
        check("s4_id_pc", id_pc, 32'h200);
        check("s4_id_valid", {31'b0, id_valid}, 32'd1);

        // 5: PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("s5_imem_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("s5_id_pc_top", id_pc, 32'hFFFF_FFFC);
        check("s5_id_pc_plus4_wrap", id_pc_plus4, 32'h0);
        check("s5_imem_addr_wrap", imem_addr, 32'h0);
        step();
        check("s5_id_pc_zero", id_pc, 32'h0);
        check("s5_id_instr_zero", id_instr, 32'h1000_0000);

        // 6: reset mid-stream with a full queue and a misaligned redirect pending
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("s6_full_valid", {31'b0, id_valid}, 32'd1);
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0303;
        step();
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        #1;
        check("s6_id_valid", {31'b0, id_valid}, 32'd0);
        check("s6_imem_addr", imem_addr, 32'h0);
        check("s6_align_err", {31'b0, align_err}, 32'd0);
        check("s6_id_pc_plus4", id_pc_plus4, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
